quantum_measurement_unit: RTL

//  Projective-measurement stage feeding the QAOA optimizer. Samples one basis state from the
//  16-bit support mask the optimizer drives on quantum_state; applies optional per-qubit readout noise.

---
 rtl/quantum_measurement_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/quantum_measurement_unit.sv
// -----------------------------------------------------------------------------
// quantum_measurement_unit
//   Projective-measurement stage. On each request it latches the 16-bit support
//   mask, draws a random starting basis index from a 32-bit Galois LFSR, scans
//   the mask circularly from that index to the first supported basis state,
//   optionally flips each of the 4 measured qubits (readout noise), and returns
//   the result with a one-cycle valid pulse.
//
// Ports
//   clk                    clock, all state updates on the rising edge
//   rst                    asynchronous reset, active low
//   measure_req            request one measurement (level-sampled every cycle)
//   quantum_state[15:0]    support mask, bit k = basis state k is possible
//   noise_level[7:0]       per-qubit flip threshold, 0 = noiseless
//   seed_load              load the LFSR from seed_value this cycle
//   seed_value[31:0]       LFSR seed (zero is replaced by LFSR_SEED)
//   quantum_measurement    [3:0] measured basis index, [15:4] always zero
//   quantum_measure_valid  one-cycle pulse, quantum_measurement is fresh
//   busy                   high whenever the FSM is not idle
//   error                  one-cycle pulse, the latched mask was all-zero
//   measure_count          number of valid pulses issued (wraps)
//   dropped_count          number of requests discarded (wraps)
// -----------------------------------------------------------------------------
module quantum_measurement_unit #(
    parameter logic [31:0] LFSR_SEED = 32'hACE12024,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             measure_req,
    input  logic [15:0]      quantum_state,
    input  logic [7:0]       noise_level,
    input  logic             seed_load,
    input  logic [31:0]      seed_value,
    output logic [15:0]      quantum_measurement,
    output logic             quantum_measure_valid,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] measure_count,
    output logic [CNT_W-1:0] dropped_count
);

    localparam logic [31:0]      LFSR_TAPS = 32'h80200003;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_SCAN,
        S_FLIP,
        S_OUT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] mask;
    logic [3:0]  idx;
    logic [3:0]  scan_cnt;
    logic [3:0]  meas;
    logic        pending;
    logic [31:0] lfsr;
    logic [31:0] lfsr_shift;
    logic        scan_hit;
    logic        start;
    logic        busy_req;

    // Right-shifting Galois form: the bit falling out of the LSB folds the taps back in.
    assign lfsr_shift = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 32'h0);

    // scan_cnt bounds the walk defensively; a nonzero mask always hits by the 16th test.
    assign scan_hit = mask[idx] || (scan_cnt == 4'd15);

    // A request left pending by the OUT cycle is serviced as soon as we are idle again.
    assign start    = measure_req || pending;

    // Requests that arrive mid-measurement; OUT handles its own arrivals below.
    assign busy_req = measure_req &&
                      ((state == S_DRAW) || (state == S_SCAN) || (state == S_FLIP));

    assign busy                  = (state != S_IDLE);
    assign quantum_measure_valid = (state == S_OUT);
    assign quantum_measurement   = {12'h000, meas};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_DRAW;
            S_DRAW:  state_next = (mask == 16'h0000) ? S_IDLE : S_SCAN;
            S_SCAN:  if (scan_hit) state_next = S_FLIP;
            S_FLIP:  state_next = S_OUT;
            S_OUT:   state_next = pending ? S_DRAW : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask          <= 16'h0000;
            idx           <= 4'h0;
            scan_cnt      <= 4'h0;
            meas          <= 4'h0;
            pending       <= 1'b0;
            lfsr          <= LFSR_SEED;
            error         <= 1'b0;
            measure_count <= '0;
            dropped_count <= '0;
        end else begin
            error <= 1'b0;

            // A seed load always wins over the per-draw shift.
            if (seed_load) begin
                lfsr <= (seed_value == 32'h0) ? LFSR_SEED : seed_value;
            end else if ((state == S_DRAW) || (state == S_FLIP)) begin
                lfsr <= lfsr_shift;
            end

            if (busy_req) begin
                if (pending) begin
                    dropped_count <= dropped_count + CNT_ONE;
                end else begin
                    pending <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask    <= quantum_state;
                        // With both a pending and a fresh request, one is consumed here.
                        pending <= pending && measure_req;
                    end
                end
                S_DRAW: begin
                    if (mask == 16'h0000) begin
                        error <= 1'b1;
                    end else begin
                        idx      <= lfsr[3:0];
                        scan_cnt <= 4'h0;
                    end
                end
                S_SCAN: begin
                    if (!scan_hit) begin
                        idx      <= idx + 4'd1;
                        scan_cnt <= scan_cnt + 4'd1;
                    end
                end
                S_FLIP: begin
                    // Qubit j flips when its own LFSR byte falls below the threshold.
                    for (int j = 0; j < 4; j++) begin
                        meas[j] <= idx[j] ^ (lfsr[8*j +: 8] < noise_level);
                    end
                end
                S_OUT: begin
                    measure_count <= measure_count + CNT_ONE;
                    if (pending) begin
                        // The pending request is serviced now; a fresh one re-arms it.
                        mask    <= quantum_state;
                        pending <= measure_req;
                    end else if (measure_req) begin
                        pending <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
